// File: rtl/aes_block_packer.sv
// rtl/aes_block_packer.sv - packs four 32-bit FIFO words into one 128-bit AES input block
//
// Pops words from the AXI slave FIFO read port, assembles four of them into a
// block and hands the block to the AES datapath over a valid/ready handshake.
// WORD_W must be 32 and BLOCK_W must be 4*WORD_W; other values are unsupported.
//
// Ports:
//   s00_axi_aclk     clock, all state updates on the rising edge
//   s00_axi_aresetn  synchronous active-low reset
//   fifo_empty       FIFO has no words available
//   fifo_rd_en       pop request, one word per cycle while high
//   fifo_rd_data     popped word, valid the cycle after fifo_rd_en
//   clear            synchronous abort of the partial block being filled
//   m_block_valid    m_block_data holds a complete block
//   m_block_ready    AES core accepts the block
//   m_block_data     packed block
//   busy             a block is being filled or is waiting to be taken
//   blocks_out       delivered-block count, wraps modulo 2^CNT_W

module aes_block_packer #(
   parameter int WORD_W    = 32,
   parameter int BLOCK_W   = 128,
   parameter int MSW_FIRST = 1,
   parameter int CNT_W     = 16
) (
   input  logic               s00_axi_aclk,
   input  logic               s00_axi_aresetn,
   input  logic               fifo_empty,
   output logic               fifo_rd_en,
   input  logic [WORD_W-1:0]  fifo_rd_data,
   input  logic               clear,
   output logic               m_block_valid,
   input  logic               m_block_ready,
   output logic [BLOCK_W-1:0] m_block_data,
   output logic               busy,
   output logic [CNT_W-1:0]   blocks_out
);

   typedef enum logic {ST_FILL, ST_HOLD} state_t;

   state_t             state_q, state_d;
   logic [2:0]         issued_q, issued_d;     // pops requested for this block
   logic [2:0]         captured_q, captured_d; // words landed in slots
   logic               rd_pend_q, rd_pend_d;   // a popped word arrives this cycle
   logic [BLOCK_W-1:0] slots_q, slots_d;
   logic [BLOCK_W-1:0] data_q, data_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [1:0]         slot_idx;

   // Slot k lands at word position 3-k when the first word is the most
   // significant one, otherwise at position k.
   assign slot_idx = (MSW_FIRST != 0) ? (2'd3 - captured_q[1:0]) : captured_q[1:0];

   always_comb begin
      state_d    = state_q;
      issued_d   = issued_q;
      captured_d = captured_q;
      rd_pend_d  = 1'b0;
      slots_d    = slots_q;
      data_d     = data_q;
      valid_d    = valid_q;
      count_d    = count_q;
      fifo_rd_en = 1'b0;

      case (state_q)
         ST_FILL: begin
            fifo_rd_en = !fifo_empty && (issued_q < 3'd4) && !clear;
            rd_pend_d  = fifo_rd_en;
            if (clear) begin
               // A word arriving in this cycle is dropped along with the slots.
               issued_d   = 3'd0;
               captured_d = 3'd0;
               slots_d    = '0;
            end else begin
               if (fifo_rd_en) begin
                  issued_d = issued_q + 3'd1;
               end
               if (rd_pend_q) begin
                  slots_d[slot_idx*WORD_W +: WORD_W] = fifo_rd_data;
                  captured_d = captured_q + 3'd1;
                  if (captured_q == 3'd3) begin
                     // Fourth word: publish the block including this word.
                     data_d  = slots_d;
                     valid_d = 1'b1;
                     state_d = ST_HOLD;
                  end
               end
            end
         end
         ST_HOLD: begin
            // clear is ignored here so a completed block is never lost.
            if (m_block_ready) begin
               valid_d    = 1'b0;
               issued_d   = 3'd0;
               captured_d = 3'd0;
               count_d    = count_q + 1'b1;
               state_d    = ST_FILL;
            end
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         state_q    <= ST_FILL;
         issued_q   <= 3'd0;
         captured_q <= 3'd0;
         rd_pend_q  <= 1'b0;
         slots_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         issued_q   <= issued_d;
         captured_q <= captured_d;
         rd_pend_q  <= rd_pend_d;
         slots_q    <= slots_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         count_q    <= count_d;
      end
   end

   assign m_block_valid = valid_q;
   assign m_block_data  = data_q;
   assign blocks_out    = count_q;
   assign busy          = (issued_q != 3'd0) || (state_q == ST_HOLD);

   a_issued_max: assert property (@(posedge s00_axi_aclk)
      disable iff (!s00_axi_aresetn) issued_q <= 3'd4);
   a_captured_max: assert property (@(posedge s00_axi_aclk)
      disable iff (!s00_axi_aresetn) captured_q <= 3'd4);

endmodule
